// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants and the multiplier FSM state type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fp32_pkg;

    localparam int FP_WIDTH   = 32;
    localparam int EXP_WIDTH  = 8;
    localparam int MANT_WIDTH = 23;
    localparam int BIAS       = 127;

    localparam logic [FP_WIDTH-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXP  = 3'd1,
        MUL  = 3'd2,
        NORM = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/fp_mul_exp_calc.sv
// Sign, biased exponent sum, hidden-bit mantissas and special-case result for an fp32 product.
// Latency: purely combinational.
// Backpressure: none; the caller holds operands stable while it uses the outputs.
module fp_mul_exp_calc
    import fp32_pkg::*;
(
    input  logic [FP_WIDTH-1:0]   a,
    input  logic [FP_WIDTH-1:0]   b,
    output logic                  sign,
    output logic [EXP_WIDTH+1:0]  exp_sum,
    output logic [MANT_WIDTH:0]   mant_a,
    output logic [MANT_WIDTH:0]   mant_b,
    output logic                  special,
    output logic [FP_WIDTH-1:0]   special_res
);

    logic [EXP_WIDTH-1:0] ea, eb;
    logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    // Classify both operands and pick the shortcut result where one applies.
    always_comb begin
        ea      = a[30:23];
        eb      = b[30:23];
        sign    = a[31] ^ b[31];
        // Ten bits signed: covers -127 .. 381 before normalisation bumps.
        exp_sum = {2'b00, ea} + {2'b00, eb} - 10'(BIAS);
        mant_a  = {1'b1, a[22:0]};
        mant_b  = {1'b1, b[22:0]};

        a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
        a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
        // Subnormals are flushed, so any zero exponent counts as zero.
        a_zero  = (ea == 8'h00);
        b_zero  = (eb == 8'h00);

        special     = 1'b1;
        special_res = QNAN;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            special_res = QNAN;
        end else if (a_inf || b_inf) begin
            special_res = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            special_res = {sign, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential fp32 multiplier: shift-add 24x24 mantissa product, round-to-nearest-even, FTZ.
// Latency: out_valid after 26 edges from accept (1 edge for NaN/inf/zero operands).
// Backpressure: single operation in flight; result held in DONE until out_ready.
module fp_mul_seq
    import fp32_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FP_WIDTH-1:0] mul1,
    input  logic [FP_WIDTH-1:0] mul2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FP_WIDTH-1:0] result,
    output logic                busy
);

    state_t                state_q, state_d;
    logic [FP_WIDTH-1:0]   a_q, b_q, result_q;
    logic [47:0]           acc_q;
    logic [4:0]            cnt_q;

    logic                  sign;
    logic [EXP_WIDTH+1:0]  exp_sum;
    logic [MANT_WIDTH:0]   mant_a, mant_b;
    logic                  special;
    logic [FP_WIDTH-1:0]   special_res;

    // Operands are captured once, so the exponent logic sees them stable for the whole operation.
    fp_mul_exp_calc u_exp_calc (
        .a           (a_q),
        .b           (b_q),
        .sign        (sign),
        .exp_sum     (exp_sum),
        .mant_a      (mant_a),
        .mant_b      (mant_b),
        .special     (special),
        .special_res (special_res)
    );

    logic [9:0]  e_n, e_f;
    logic [22:0] m_n;
    logic        g, s, rnd;
    logic [23:0] m_r;
    logic [31:0] norm_res;

    // Normalise the 48-bit product, round to nearest even, then saturate the exponent.
    always_comb begin
        if (acc_q[47]) begin
            m_n = acc_q[46:24];
            g   = acc_q[23];
            s   = |acc_q[22:0];
            e_n = exp_sum + 10'd1;
        end else begin
            m_n = acc_q[45:23];
            g   = acc_q[22];
            s   = |acc_q[21:0];
            e_n = exp_sum;
        end
        rnd = g & (s | m_n[0]);
        m_r = {1'b0, m_n} + {23'd0, rnd};
        // A rounding carry leaves the fraction all-zero, so only the exponent moves.
        e_f = m_r[23] ? (e_n + 10'd1) : e_n;
        if ($signed(e_f) >= 10'sd255) begin
            norm_res = {sign, 8'hFF, 23'd0};
        end else if ($signed(e_f) <= 10'sd0) begin
            norm_res = {sign, 31'd0};
        end else begin
            norm_res = {sign, e_f[7:0], m_r[22:0]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = EXP;
            end
            EXP:  state_d = special ? DONE : MUL;
            MUL:  if (cnt_q == 5'd23) state_d = NORM;
            NORM: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, one multiplier bit per MUL cycle, result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= mul1;
                        b_q   <= mul2;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                EXP: begin
                    if (special) result_q <= special_res;
                end
                MUL: begin
                    if (mant_b[cnt_q]) acc_q <= acc_q + ({24'd0, mant_a} << cnt_q);
                    cnt_q <= (cnt_q == 5'd23) ? 5'd0 : cnt_q + 5'd1;
                end
                NORM: result_q <= norm_res;
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mul1, mul2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;

    fp_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul1      (mul1),
        .mul2      (mul2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    // Accept one operand pair, scramble inputs afterwards, measure latency, check result.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
        int cycles;
        @(negedge clk);
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        mul1 = a;
        mul2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mul1 = $urandom;
        mul2 = $urandom;
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({name, " latency"}, cycles, exp_lat);
        check({name, " result"}, result, exp_res);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int cycles;
        logic [31:0] held;

        vecs[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 26, "1.5x2"};
        vecs[1] = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 1,  "0xinf"};
        vecs[2] = '{32'hC0000000, 32'h7F800000, 32'hFF800000, 1,  "-2xinf"};
        vecs[3] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 26, "overflow"};
        vecs[4] = '{32'h00800000, 32'h3F000000, 32'h00000000, 26, "ftz"};
        vecs[5] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 26, "round"};
        vecs[6] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1,  "nan"};
        vecs[7] = '{32'hC0400000, 32'h40000000, 32'hC0C00000, 26, "-3x2"};
        vecs[8] = '{32'h40000000, 32'h7F800000, 32'h7F800000, 1,  "2xinf"};
        vecs[9] = '{32'h80000000, 32'h3F800000, 32'h80000000, 1,  "-0x1"};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        mul1 = '0;
        mul2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].name);
        end

        // Back-pressure: hold result in DONE while in_valid pokes at the input.
        @(negedge clk);
        in_valid = 1'b1;
        mul1 = 32'h3FC00000;
        mul2 = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("bp latency", cycles, 26);
        held = 32'h40400000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            mul1 = 32'h3F800000;
            mul2 = 32'h3F800000;
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
            check("bp result", result, held);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        // Output handshake with in_valid still high: that edge must not accept.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handshake busy", {31'd0, busy}, 32'd0);
        check("handshake in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("accept after idle", {31'd0, busy}, 32'd1);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("late accept result", result, 32'h3F800000);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of MUL aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        mul1 = 32'h3FC00000;
        mul2 = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset in_ready", {31'd0, in_ready}, 32'd1);
        check("post-reset out_valid", {31'd0, out_valid}, 32'd0);
        run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 26, "1x1 after reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-005 SHALL have ports mul1 and mul2, input, 32 bits each: IEEE-754 single operands.
REQ-006 SHALL have port out_valid, output, 1 bit: result valid.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-008 SHALL have port result, output, 32 bits: IEEE-754 single product.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 SHALL implement states IDLE, EXP, MUL, NORM and DONE.
REQ-011 SHALL set in_ready=1 only in IDLE; input handshake is in_valid&&in_ready, operands registered, next state EXP.
REQ-012 EXP (1 cycle) SHALL compute sign = s1^s2, 10-bit signed exponent e1+e2-127, special-case class, and mantissas {1,m} (24 bits).
REQ-013 Special cases SHALL be detected in EXP and SHALL skip directly to DONE:
- NaN operand, or inf*zero -> 0x7FC00000
- inf*finite-nonzero -> signed inf
- zero or subnormal operand (exp==0) -> signed zero; subnormals flushed to zero
REQ-014 MUL SHALL perform shift-add 24x24->48 multiply, one multiplier bit per cycle, 5-bit counter 0..23, exactly 24 cycles, then go to NORM.
REQ-015 NORM (1 cycle) SHALL perform the following:
- if product bit47=1: shift right 1 and increment exponent
- round to nearest even using guard bit plus sticky OR of remaining bits
- on mantissa carry-out from rounding: increment exponent again
REQ-016 After NORM the final exponent SHALL saturate: >=255 -> signed inf (0x7F800000|sign); <=0 -> signed zero (no subnormal output).
REQ-017 DONE SHALL hold out_valid=1 with result stable until out_ready=1; on the output handshake the next state SHALL be IDLE.
REQ-018 Latency SHALL be: input handshake at edge N -> out_valid high after edge N+26 (normal) or N+1 (special case).
REQ-019 SHALL accept no new operands while busy; in_valid in non-IDLE states SHALL be ignored.
REQ-020 SHALL make in_valid in the same cycle as the DONE output handshake not accepted; operands are accepted the following IDLE cycle.
REQ-021 SHALL ignore changes on mul1/mul2 after acceptance.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force the following:
- state IDLE
- out_valid=0, result=0, busy=0, counter=0, product accumulator=0
REQ-023 Reset asserted in any state, including mid-MUL, SHALL abort the operation with no result produced; in_ready=1 on the first cycle after rst_n returns high.

Structure
REQ-024 Shared package fp32_pkg SHALL hold the following:
- FP_WIDTH=32, EXP_WIDTH=8, MANT_WIDTH=23, BIAS=127
- canonical QNAN=0x7FC00000
- state enum type
REQ-025 Exponent/special-case logic SHALL be a combinational sub-module fp_mul_exp_calc; the FSM, shift-add datapath and rounding stay in fp_mul_seq.

Verification
REQ-026 0x3FC00000 * 0x40000000 -> result 0x40400000, out_valid exactly 26 cycles after the accept edge.
REQ-027 0x00000000 * 0x7F800000 -> 0x7FC00000 one cycle after accept; 0xC0000000 * 0x7F800000 -> 0xFF800000.
REQ-028 0x7F000000 * 0x7F000000 -> 0x7F800000; 0x00800000 * 0x3F000000 -> 0x00000000 (FTZ underflow).
REQ-029 0x3F800001 * 0x3F800001 -> 0x3F800002 (rounding check).
REQ-030 Back-pressure: out_ready held 0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0, in_valid ignored.
REQ-031 rst_n=0 at cycle 10 of MUL -> out_valid=0, busy=0, in_ready=1 after release; a subsequent 1.0*1.0 returns 0x3F800000.
